adc_sequencer: RTL and testbench

//  Single-clock conversion sequencer placed directly upstream of the adc macro.
//  It generates the seq_init/seq_samp/seq_comp/seq_update timing pulses for one SAR conversion.
//  It captures the serial comp_out decisions MSB-first into a parallel result word.
//  It provides a start/busy/done handshake to the readout logic.

---
 rtl/adc_sequencer.sv | 139 +++++++++++++
 tb/tb_adc_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sequencer.sv
// SAR conversion sequencer: drives the adc init/sample/compare/update strobes
// and assembles the MSB-first comparator decisions into a parallel result word.
module adc_sequencer #(
    parameter int NBITS    = 16,
    parameter int T_SAMP   = 4,
    parameter int T_COMP   = 1,
    parameter int T_UPDATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             comp_out,
    output logic             seq_init,
    output logic             seq_samp,
    output logic             seq_comp,
    output logic             seq_update,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             result_valid,
    output logic             overrun
);

    localparam int T_MAX = (T_SAMP > T_COMP) ? ((T_SAMP > T_UPDATE) ? T_SAMP : T_UPDATE)
                                             : ((T_COMP > T_UPDATE) ? T_COMP : T_UPDATE);
    localparam int TMR_W = $clog2(T_MAX) + 1;
    localparam int IDX_W = $clog2(NBITS) + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_SAMP   = 3'd2;
    localparam logic [2:0] ST_COMP   = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    generate
        if (NBITS < 1 || NBITS > 16 || T_SAMP < 1 || T_COMP < 1 || T_UPDATE < 1) begin : g_bad_params
            $error("adc_sequencer: illegal parameter set");
        end
    endgenerate

    logic [2:0]       state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [IDX_W-1:0] bit_idx, idx_nxt;
    logic [NBITS-1:0] shadow, shadow_nxt, result_nxt;

    // Each timed state loads its duration minus one on entry and leaves at zero.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        idx_nxt    = bit_idx;
        shadow_nxt = shadow;
        result_nxt = result;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_INIT;
            end
            ST_INIT: begin
                state_nxt  = ST_SAMP;
                timer_nxt  = TMR_W'(T_SAMP - 1);
                idx_nxt    = '0;
                shadow_nxt = '0;
            end
            ST_SAMP: begin
                if (timer == '0) begin
                    state_nxt = ST_COMP;
                    timer_nxt = TMR_W'(T_COMP - 1);
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            ST_COMP: begin
                if (timer == '0) begin
                    state_nxt = ST_UPDATE;
                    timer_nxt = TMR_W'(T_UPDATE - 1);
                    for (int i = 0; i < NBITS; i++) begin
                        if (bit_idx == IDX_W'(NBITS - 1 - i)) shadow_nxt[i] = comp_out;
                    end
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            ST_UPDATE: begin
                if (timer == '0) begin
                    if (bit_idx < IDX_W'(NBITS - 1)) begin
                        state_nxt = ST_COMP;
                        timer_nxt = TMR_W'(T_COMP - 1);
                        idx_nxt   = bit_idx + IDX_W'(1);
                    end else begin
                        state_nxt  = ST_DONE;
                        result_nxt = shadow;
                    end
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = cont ? ST_INIT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode so they line up with the state they mark.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            result       <= '0;
            seq_init     <= 1'b0;
            seq_samp     <= 1'b0;
            seq_comp     <= 1'b0;
            seq_update   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            bit_idx      <= idx_nxt;
            result       <= result_nxt;
            seq_init     <= (state_nxt == ST_INIT);
            seq_samp     <= (state_nxt == ST_SAMP);
            seq_comp     <= (state_nxt == ST_COMP);
            seq_update   <= (state_nxt == ST_UPDATE);
            busy         <= (state_nxt != ST_IDLE);
            result_valid <= (state_nxt == ST_DONE);
        end
    end

    // Decision scratch word; always cleared in INIT before any bit lands, so no reset needed.
    always_ff @(posedge clk) begin
        shadow <= shadow_nxt;
    end

    // Flags the very cycle a start is ignored; a start in DONE with cont set simply merges.
    assign overrun = start && busy && !(state == ST_DONE && cont);

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: a cycle-position reference model checks a small instance
// every cycle; directed scenarios pin exact cycle numbers, plus a default-size instance.
module tb_adc_sequencer;

    localparam int NB = 4;
    localparam int TS = 2;
    localparam int TC = 1;
    localparam int TU = 1;
    localparam int P  = TC + TU;
    localparam int L  = 2 + TS + NB * P;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, cont = 1'b0, comp_out = 1'b0;
    logic seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun;
    logic [NB-1:0] result;

    logic b_start = 1'b0, b_cont = 1'b0, b_comp = 1'b0;
    logic b_init, b_samp, b_scomp, b_update, b_busy, b_rv, b_ovr;
    logic [15:0] b_result;

    int n_cmp = 0;
    int n_bad = 0;

    adc_sequencer #(.NBITS(NB), .T_SAMP(TS), .T_COMP(TC), .T_UPDATE(TU)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .comp_out(comp_out),
        .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp), .seq_update(seq_update),
        .busy(busy), .result(result), .result_valid(result_valid), .overrun(overrun)
    );

    adc_sequencer dut_def (
        .clk(clk), .rst(rst), .start(b_start), .cont(b_cont), .comp_out(b_comp),
        .seq_init(b_init), .seq_samp(b_samp), .seq_comp(b_scomp), .seq_update(b_update),
        .busy(b_busy), .result(b_result), .result_valid(b_rv), .overrun(b_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Comparator stimulus: pattern bit during the COMP cycles of a conversion whose INIT is at s0.
    function automatic logic pb(int c, int s0, logic [NB-1:0] p);
        int k;
        k = c - s0 - 1 - TS;
        if (k >= 0 && k < NB * P && (k % P) < TC) return p[NB-1-k/P];
        return 1'($urandom);
    endfunction

    // Reference model: m_t is the cycle position inside the current conversion (0 = INIT).
    bit            m_act = 1'b0;
    int            m_t = 0;
    int            mk;
    logic [NB-1:0] m_shadow = '0;
    logic [NB-1:0] m_result = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act = 1'b0; m_t = 0; m_shadow = '0; m_result = '0;
        end else if (m_act) begin
            mk = m_t - 1 - TS;
            if (mk >= 0 && mk < NB * P && (mk % P) == TC - 1) m_shadow[NB-1-mk/P] = comp_out;
            if (m_t == L - 2) m_result = m_shadow;
            if (m_t == L - 1) begin
                if (cont) begin m_t = 0; m_shadow = '0; end
                else m_act = 1'b0;
            end else begin
                m_t++;
            end
        end else if (start) begin
            m_act = 1'b1; m_t = 0; m_shadow = '0;
        end
    end

    logic [6:0] e_ctl, a_ctl;
    int ek;
    always @(negedge clk) begin
        ek = m_t - 1 - TS;
        e_ctl[6] = m_act && m_t == 0;
        e_ctl[5] = m_act && m_t >= 1 && m_t <= TS;
        e_ctl[4] = m_act && ek >= 0 && ek < NB * P && (ek % P) < TC;
        e_ctl[3] = m_act && ek >= 0 && ek < NB * P && (ek % P) >= TC;
        e_ctl[2] = m_act;
        e_ctl[1] = m_act && m_t == L - 1;
        e_ctl[0] = m_act && start && !(m_t == L - 1 && cont);
        a_ctl = {seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun};
        chk("ctl{init,samp,comp,upd,busy,rv,ovr}", 32'(a_ctl), 32'(e_ctl));
        chk("result", 32'(result), 32'(m_result));
    end

    int ncomp;

    initial begin
        tick(); tick();
        chk("reset_ctl", 32'({seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun}), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        rst = 1'b1;

        // single shot, decisions 1,0,1,1
        for (int c = 0; c <= 14; c++) begin
            start = (c == 0); cont = 1'b0; comp_out = pb(c, 1, 4'b1011);
            #2;
            if (c == 1)  chk("t1_seq_init", 32'(seq_init), 32'd1);
            if (c == 3)  chk("t1_seq_samp", 32'(seq_samp), 32'd1);
            if (c == 11) chk("t1_seq_update", 32'(seq_update), 32'd1);
            if (c == 12) begin
                chk("t1_result", 32'(result), 32'hB);
                chk("t1_rv", 32'(result_valid), 32'd1);
            end
            if (c == 13) chk("t1_idle", 32'(busy), 32'd0);
            tick();
        end

        // continuous mode, 0110 then 1111 with no idle gap
        for (int c = 0; c <= 26; c++) begin
            start = (c == 0); cont = (c <= 13);
            comp_out = (c < 13) ? pb(c, 1, 4'b0110) : pb(c, 13, 4'b1111);
            #2;
            if (c == 12) begin
                chk("t2_rv1", 32'(result_valid), 32'd1);
                chk("t2_res1", 32'(result), 32'h6);
            end
            if (c == 13) chk("t2_init_nogap", 32'(seq_init), 32'd1);
            if (c == 24) begin
                chk("t2_rv2", 32'(result_valid), 32'd1);
                chk("t2_res2", 32'(result), 32'hF);
            end
            if (c == 25) chk("t2_idle", 32'(busy), 32'd0);
            tick();
        end

        // overrun from a second start mid-conversion
        for (int c = 0; c <= 15; c++) begin
            start = (c == 0 || c == 5); cont = 1'b0; comp_out = pb(c, 1, 4'b1100);
            #2;
            if (c == 5) chk("t3_overrun", 32'(overrun), 32'd1);
            if (c == 6) chk("t3_overrun_drop", 32'(overrun), 32'd0);
            if (c == 12) chk("t3_result", 32'(result), 32'hC);
            if (c == 14) chk("t3_no_second", 32'(busy), 32'd0);
            tick();
        end

        // asynchronous reset in cycle 7
        for (int c = 0; c <= 7; c++) begin
            start = (c == 0); comp_out = pb(c, 1, 4'b0101);
            #2;
            if (c == 7) begin
                rst = 1'b0;
                #1;
                chk("t4_rst_ctl", 32'({seq_init, seq_samp, seq_comp, seq_update, busy, result_valid}), 32'd0);
                chk("t4_rst_result", 32'(result), 32'd0);
            end
            tick();
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            start = (c == 0); comp_out = pb(c, 1, 4'b0011);
            #2;
            if (c == 12) chk("t4_after_rst", 32'(result), 32'h3);
            tick();
        end

        // default-size instance, alternating decisions starting at 1
        ncomp = 0;
        for (int c = 0; c <= 40; c++) begin
            b_start = (c == 0);
            b_comp = (c >= 6) ? (((c - 6) / 2) % 2 == 0) : 1'($urandom);
            #2;
            if (b_scomp) ncomp++;
            if (c == 37) chk("t5_rv_early", 32'(b_rv), 32'd0);
            if (c == 38) begin
                chk("t5_rv", 32'(b_rv), 32'd1);
                chk("t5_result", 32'(b_result), 32'hAAAA);
            end
            if (c == 39) chk("t5_idle", 32'(b_busy), 32'd0);
            tick();
        end
        chk("t5_comp_count", 32'(ncomp), 32'd16);

        // start held high, cont low
        for (int c = 0; c <= 30; c++) begin
            start = 1'b1; cont = 1'b0; comp_out = 1'($urandom);
            #2;
            if (c == 5)  chk("t6_overrun_busy", 32'(overrun), 32'd1);
            if (c == 12) chk("t6_overrun_done", 32'(overrun), 32'd1);
            if (c == 13) begin
                chk("t6_idle_gap", 32'(busy), 32'd0);
                chk("t6_no_ovr_idle", 32'(overrun), 32'd0);
            end
            if (c == 14) chk("t6_reinit", 32'(seq_init), 32'd1);
            if (c == 26) chk("t6_idle_gap2", 32'(busy), 32'd0);
            if (c == 27) chk("t6_reinit2", 32'(seq_init), 32'd1);
            tick();
        end
        start = 1'b0;
        repeat (15) tick();

        // randomized traffic with occasional mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            if (!rst) rst = 1'b1;
            start = ($urandom_range(0, 7) == 0);
            cont = ($urandom_range(0, 3) == 0);
            comp_out = 1'($urandom);
            #2;
            if ($urandom_range(0, 399) == 0) rst = 1'b0;
            tick();
        end
        rst = 1'b1;
        start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
